// File: rtl/icache_loader_if.sv
// icache_loader_if: byte-stream, icache write-port and control signals
// of the icache boot loader, bundled for the loader (master) and its environment (slave).
//   start_i/nwords_i/abort_i      load control
//   byte_valid_i/byte_data_i/byte_ready_o  byte-stream handshake
//   we_o/wraddr_o/wrdata_o        icache write port
//   busy_o/done_o/core_rst_no     status and core reset
interface icache_loader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              start_i;
    logic [ADDR_W:0]   nwords_i;
    logic              abort_i;
    logic              byte_valid_i;
    logic [7:0]        byte_data_i;
    logic              byte_ready_o;
    logic              we_o;
    logic [ADDR_W-1:0] wraddr_o;
    logic [DATA_W-1:0] wrdata_o;
    logic              busy_o;
    logic              done_o;
    logic              core_rst_no;

    modport master (
        input  start_i, nwords_i, abort_i,
        input  byte_valid_i, byte_data_i,
        output byte_ready_o,
        output we_o, wraddr_o, wrdata_o,
        output busy_o, done_o, core_rst_no
    );

    modport slave (
        output start_i, nwords_i, abort_i,
        output byte_valid_i, byte_data_i,
        input  byte_ready_o,
        input  we_o, wraddr_o, wrdata_o,
        input  busy_o, done_o, core_rst_no
    );
endinterface

// File: rtl/icache_loader.sv
// icache_loader: packs a little-endian byte stream into words, writes them to
// consecutive icache addresses and holds the core in reset until the load completes.
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   bus     icache_loader_if.master (control, byte handshake, write port, status)
module icache_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    icache_loader_if.master bus
);

    localparam int LANES = DATA_W / 8;
    localparam int BC_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(1) << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] word_q;
    logic [BC_W-1:0]   byte_q;
    logic [DATA_W-1:0] buf_q;
    logic [ADDR_W-1:0] wraddr_q;
    logic [DATA_W-1:0] wrdata_q;
    logic              core_rst_q;

    logic              ready;
    logic              xfer;
    logic              we;
    logic              start_ok;
    logic              last_lane;
    logic              last_word;
    logic [ADDR_W:0]   n_eff;
    logic [ADDR_W:0]   n_m1;

    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        xfer     = 1'b0;
        we       = 1'b0;
        start_ok = 1'b0;
        // Zero or oversize counts mean "fill the whole cache".
        n_eff = bus.nwords_i;
        if (bus.nwords_i == '0 || bus.nwords_i > FULL) begin
            n_eff = FULL;
        end
        n_m1      = n_eff - (ADDR_W + 1)'(1);
        last_lane = (byte_q == BC_W'(LANES - 1));
        last_word = (word_q == last_q);
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    start_ok = 1'b1;
                    state_d  = RECV;
                end
            end
            RECV: begin
                // Abort blocks the transfer in the same cycle.
                ready = ~bus.abort_i;
                xfer  = ready & bus.byte_valid_i;
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (xfer && last_lane) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else begin
                    we      = 1'b1;
                    state_d = last_word ? DONE : RECV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= '0;
            word_q     <= '0;
            byte_q     <= '0;
            buf_q      <= '0;
            wraddr_q   <= '0;
            wrdata_q   <= '0;
            core_rst_q <= 1'b0;
        end else begin
            if (start_ok) begin
                last_q     <= n_m1[ADDR_W-1:0];
                word_q     <= '0;
                byte_q     <= '0;
                core_rst_q <= 1'b0;
            end
            if (xfer) begin
                buf_q[{byte_q, 3'b000} +: 8] <= bus.byte_data_i;
                byte_q <= byte_q + BC_W'(1);
            end
            if (we) begin
                wraddr_q <= word_q;
                wrdata_q <= buf_q;
                byte_q   <= '0;
                if (last_word) begin
                    // Release the core together with the done pulse.
                    core_rst_q <= 1'b1;
                end else begin
                    word_q <= word_q + ADDR_W'(1);
                end
            end
        end
    end

    // The write port shows the live word only while we_o is high,
    // otherwise it holds the last word written.
    assign bus.byte_ready_o = ready;
    assign bus.we_o         = we;
    assign bus.wraddr_o     = we ? word_q : wraddr_q;
    assign bus.wrdata_o     = we ? buf_q : wrdata_q;
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.done_o       = (state_q == DONE);
    assign bus.core_rst_no  = core_rst_q;

endmodule
